piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a one-word holding buffer for gap-free back-to-back frames, selectable bit order, and a bit-rate enable. It is the next generation of our fixed 4-bit PISO shift register and sits between a word-wide producer and a serial line driver (UART/SPI-style TX path). It drives serial bits with frame markers so downstream logic can delimit words.

## Interface
- WIDTH, 8: word width in bits; legal range WIDTH >= 2.
- LSB_FIRST, 0: 0 = shift out MSB first, 1 = LSB first.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_data.
- in_data  input  WIDTH  parallel word.
- in_ready  output  1  holding buffer empty; word accepted when in_valid && in_ready at a rising edge.
- shift_en  input  1  bit-rate strobe; one bit advances per edge with shift_en=1.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit.
- frame_start  output  1  current bit is bit 0 of a frame.
- frame_end  output  1  current bit is last bit of a frame.
- busy  output  1  shifter active or holding buffer full.

## Operation
- State: hold buffer hbuf[WIDTH] + flag hfull; shift register sreg[WIDTH]; bit counter cnt (clog2(WIDTH) bits); FSM {IDLE, SHIFT}.
- in_ready = !hfull (registered flag, no combinational path from in_valid).
- Accept: edge with in_valid && in_ready -> hbuf <= in_data, hfull <= 1. in_data is ignored when not accepted.
- IDLE with hfull=1: next edge loads sreg <= hbuf, cnt <= 0, hfull <= 0, state -> SHIFT. shift_en is not required for the load.
- SHIFT, edge with shift_en=1:
  - cnt < WIDTH-1: shift sreg (left if MSB first, right if LSB first; vacated bit 0), cnt++.
  - cnt == WIDTH-1 and hfull=1: reload from hbuf, cnt <= 0, hfull <= 0, stay SHIFT (no idle gap).
  - cnt == WIDTH-1 and hfull=0: state -> IDLE.
- SHIFT with shift_en=0: all state holds, so outputs stay stable.
- serial_out = sreg[WIDTH-1] (MSB first) or sreg[0] (LSB first) in SHIFT; 0 in IDLE.
- serial_valid = (state == SHIFT). frame_start = serial_valid && cnt == 0. frame_end = serial_valid && cnt == WIDTH-1.
- busy = (state == SHIFT) || hfull.
- A simultaneous accept and reload cannot occur: reload needs hfull=1, so in_ready=0. in_ready reasserts the cycle after the reload.
- Reset: state IDLE, cnt 0, sreg 0, hfull 0, hbuf 0. Reset mid-frame aborts the frame and discards any buffered word. No partial bits appear after reset.

## Timing
- Reset values of outputs: in_ready=1, serial_out=0, serial_valid=0, frame_start=0, frame_end=0, busy=0.
- Latency from idle:
  - Word accepted at edge N: hfull=1 and in_ready=0 after N.
  - Load at edge N+1: bit 0 is on serial_out after N+1, so there are 2 edges from accept to first bit.
- Frame duration: exactly WIDTH shift_en-qualified edges after load. With shift_en tied high, one bit per cycle.
- Back-to-back: if the next word is buffered before the last bit's shift edge, frame k+1 bit 0 follows frame k's last bit on the very next cycle. serial_valid stays 1 throughout.
- The producer may present a new word while a frame shifts. At most one word is buffered; in_ready stays low until the buffer drains into the shifter.
- All outputs derive from registers only; there is no input-to-output combinational path.

## Test plan
- Reset, then WIDTH=4, LSB_FIRST=0, shift_en=1, accept 4'b1011: serial_out = 1,0,1,1 on 4 consecutive cycles starting 2 edges after accept. frame_start is on bit 0, frame_end on bit 3, then serial_valid=0 and busy=0.
- WIDTH=8, LSB_FIRST=1, accept 8'hA5: serial_out sequence 1,0,1,0,0,1,0,1. Rerun with LSB_FIRST=0: 1,0,1,0,0,1,0,1 (palindrome), so also run 8'h1E -> MSB-first 0,0,0,1,1,1,1,0 and LSB-first 0,1,1,1,1,0,0,0.
- Back-to-back: hold in_valid high with 8'hF0 then 8'h0F. The 16 bits are contiguous with serial_valid continuously 1, and in_ready pulses high for one cycle after each reload.
- shift_en pulsed every 3rd cycle with 8'hC3: each bit is held for 3 cycles, and the output order and frame_start/frame_end alignment are unchanged.
- Buffer-full backpressure: while frame 1 shifts and word 2 is buffered, drive in_valid with 8'h55. in_ready=0 and the word is not accepted until the reload. Verify no word is lost or duplicated.
- Assert reset at cnt=3 of a frame with a word buffered: the next cycle shows serial_valid=0, serial_out=0, in_ready=1, busy=0. Neither the aborted nor the buffered word is ever emitted.

Source files
------------

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in/serial-out serializer with valid/ready input, a
//            one-word holding buffer for gap-free frames and frame markers.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hbuf_q, hbuf_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             hfull_q, hfull_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_ready_q, in_ready_d;
  logic serial_out_q, serial_out_d;
  logic serial_valid_q, serial_valid_d;
  logic frame_start_q, frame_start_d;
  logic frame_end_q, frame_end_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    hbuf_d  = hbuf_q;
    hfull_d = hfull_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;

    // Accept and reload are mutually exclusive: reload needs hfull_q, accept needs !hfull_q.
    if (in_valid && !hfull_q) begin
      hbuf_d  = in_data;
      hfull_d = 1'b1;
    end

    if (state_q == IDLE) begin
      if (hfull_q) begin
        sreg_d  = hbuf_q;
        cnt_d   = '0;
        hfull_d = 1'b0;
        state_d = SHIFT;
      end
    end else if (shift_en) begin
      if (cnt_q != CNT_LAST) begin
        sreg_d = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
      end else if (hfull_q) begin
        sreg_d  = hbuf_q;
        cnt_d   = '0;
        hfull_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end

    // Outputs are computed from next-state values so they are registered yet current.
    serial_valid_d = (state_d == SHIFT);
    serial_out_d   = serial_valid_d && (LSB_FIRST ? sreg_d[0] : sreg_d[WIDTH-1]);
    frame_start_d  = serial_valid_d && (cnt_d == '0);
    frame_end_d    = serial_valid_d && (cnt_d == CNT_LAST);
    in_ready_d     = !hfull_d;
    busy_d         = serial_valid_d || hfull_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hbuf_q         <= '0;
      hfull_q        <= 1'b0;
      sreg_q         <= '0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b1;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hbuf_q         <= hbuf_d;
      hfull_q        <= hfull_d;
      sreg_q         <= sreg_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Directed and random checks of piso_serializer in three builds
//            (8-bit MSB-first, 8-bit LSB-first, 4-bit MSB-first).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic       shift_en;
  logic [7:0] in_data;

  wire [2:0] rdy, so, sv, fs, fe, bsy;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .shift_en(shift_en), .serial_out(so[0]),
    .serial_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bsy[0])
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .shift_en(shift_en), .serial_out(so[1]),
    .serial_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bsy[1])
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data[3:0]),
    .in_ready(rdy[2]), .shift_en(shift_en), .serial_out(so[2]),
    .serial_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bsy[2])
  );

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: list of accepted words not yet fully emitted, whether the
  // oldest one is on the line, and which bit of it is showing.
  logic [7:0] mw [3][2];
  int         mn   [3];
  int         mpos [3];
  bit         mld  [3];
  logic       e_sv, e_so, e_rdy, acc;

  function automatic int wid(input int k);
    return (k == 2) ? 4 : 8;
  endfunction

  function automatic logic bit_of(input int k, input logic [7:0] w, input int p);
    return (k == 1) ? w[p] : w[wid(k) - 1 - p];
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        e_sv  = (mn[k] > 0) && mld[k];
        e_so  = e_sv ? bit_of(k, mw[k][0], mpos[k]) : 1'b0;
        e_rdy = !((mn[k] == 2) || (mn[k] == 1 && !mld[k]));
        check($sformatf("mon_valid[%0d]", k), sv[k], e_sv);
        check($sformatf("mon_bit[%0d]", k), so[k], e_so);
        check($sformatf("mon_start[%0d]", k), fs[k], e_sv && mpos[k] == 0);
        check($sformatf("mon_end[%0d]", k), fe[k], e_sv && mpos[k] == wid(k) - 1);
        check($sformatf("mon_ready[%0d]", k), rdy[k], e_rdy);
        check($sformatf("mon_busy[%0d]", k), bsy[k], mn[k] > 0);
        if (reset) begin
          mn[k] = 0; mld[k] = 1'b0; mpos[k] = 0;
        end else begin
          acc = in_valid && e_rdy;
          if (mn[k] > 0 && !mld[k]) begin
            mld[k] = 1'b1; mpos[k] = 0;
          end else if (e_sv && shift_en) begin
            if (mpos[k] < wid(k) - 1) begin
              mpos[k]++;
            end else begin
              mw[k][0] = mw[k][1];
              mn[k]--;
              mld[k]  = (mn[k] > 0);
              mpos[k] = 0;
            end
          end
          if (acc) begin
            mw[k][mn[k]] = (k == 2) ? {4'h0, in_data[3:0]} : in_data;
            mn[k]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    shift_en = 1'b1;
    repeat (n) tick();
  endtask

  task automatic run8(input logic [7:0] w, input logic [7:0] seq_m,
                      input logic [7:0] seq_l, input string nm);
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    check({nm, "_latency_gap"}, sv[0], 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_msb_bit%0d", nm, i), so[0], seq_m[7-i]);
      check($sformatf("%s_lsb_bit%0d", nm, i), so[1], seq_l[7-i]);
      check($sformatf("%s_start%0d", nm, i), fs[1], i == 0);
      check($sformatf("%s_end%0d", nm, i), fe[0], i == 7);
      tick();
    end
    check({nm, "_done_valid"}, sv[1], 1'b0);
    check({nm, "_done_busy"}, bsy[0], 1'b0);
  endtask

  initial begin
    logic [3:0]  pat4;
    logic [15:0] pat16;
    logic [7:0]  patc3;
    int          seen;

    for (int k = 0; k < 3; k++) begin
      mn[k] = 0; mld[k] = 1'b0; mpos[k] = 0; mw[k][0] = '0; mw[k][1] = '0;
    end
    reset = 1'b1; in_valid = 1'b0; shift_en = 1'b0; in_data = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), rdy[k], 1'b1);
      check($sformatf("reset_valid%0d", k), sv[k], 1'b0);
      check($sformatf("reset_out%0d", k), so[k], 1'b0);
      check($sformatf("reset_start%0d", k), fs[k], 1'b0);
      check($sformatf("reset_end%0d", k), fe[k], 1'b0);
      check($sformatf("reset_busy%0d", k), bsy[k], 1'b0);
    end

    // 4-bit MSB-first word 1011
    pat4 = 4'b1011;
    shift_en = 1'b1; in_valid = 1'b1; in_data = 8'h0B;
    tick();
    in_valid = 1'b0;
    check("w4_ready_after_accept", rdy[2], 1'b0);
    check("w4_busy_after_accept", bsy[2], 1'b1);
    check("w4_valid_after_accept", sv[2], 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w4_bit%0d", i), so[2], pat4[3-i]);
      check($sformatf("w4_start%0d", i), fs[2], i == 0);
      check($sformatf("w4_end%0d", i), fe[2], i == 3);
      tick();
    end
    check("w4_done_valid", sv[2], 1'b0);
    check("w4_done_busy", bsy[2], 1'b0);
    idle(12);

    run8(8'hA5, 8'b10100101, 8'b10100101, "a5");
    idle(12);
    run8(8'h1E, 8'b00011110, 8'b01111000, "h1e");
    idle(12);

    // Back-to-back F0 then 0F
    pat16 = 16'hF00F;
    in_valid = 1'b1; in_data = 8'hF0;
    tick();
    in_data = 8'h0F;
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_valid%0d", i), sv[0], 1'b1);
      check($sformatf("b2b_bit%0d", i), so[0], pat16[15-i]);
      check($sformatf("b2b_ready%0d", i), rdy[0], (i == 0) || (i >= 8));
      if (i == 1) in_valid = 1'b0;
      tick();
    end
    check("b2b_done_valid", sv[0], 1'b0);
    check("b2b_done_busy", bsy[0], 1'b0);
    idle(12);

    // shift_en every third cycle with C3
    patc3 = 8'hC3;
    shift_en = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 24; i++) begin
      check($sformatf("slow_bit%0d", i), so[0], patc3[7 - i/3]);
      check($sformatf("slow_start%0d", i), fs[0], (i / 3) == 0);
      check($sformatf("slow_end%0d", i), fe[0], (i / 3) == 7);
      shift_en = (i % 3 == 2);
      tick();
    end
    check("slow_done_valid", sv[0], 1'b0);
    idle(12);

    // Backpressure: 3C shifting, 99 buffered, 55 waiting
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_data = 8'h99;
    tick();
    tick();
    in_data = 8'h55;
    for (int j = 0; j < 7; j++) begin
      check($sformatf("bp_ready_low%0d", j), rdy[0], 1'b0);
      tick();
    end
    check("bp_ready_after_reload", rdy[0], 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_ready_after_accept", rdy[0], 1'b0);
    idle(30);

    // Reset mid-frame with a word buffered
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_data = 8'h77;
    tick();
    tick();
    in_valid = 1'b0;
    check("abort_buffer_full", rdy[0], 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", sv[0], 1'b0);
    check("abort_out", so[0], 1'b0);
    check("abort_ready", rdy[0], 1'b1);
    check("abort_busy", bsy[0], 1'b0);
    check("abort_busy_lsb", bsy[1], 1'b0);
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      if (sv[0] || sv[1]) seen++;
      tick();
    end
    check("abort_nothing_emitted", seen == 0, 1'b1);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom());
      shift_en = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0;
    idle(40);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_model_empty%0d", k), mn[k] == 0, 1'b1);
      check($sformatf("drain_valid%0d", k), sv[k], 1'b0);
      check($sformatf("drain_busy%0d", k), bsy[k], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
